fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register for the 19-bit MIPS-like pipeline.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction fetch and IF/ID pipeline register for the 19-bit pipeline
// Optional fetch statistics counters are built when FETCH_STATS_EN is defined.
module fetch_stage #(
    parameter int                PC_W     = 12,
    parameter int                INST_W   = 19,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_writebar,
    input  logic              IF_ID_loadbar,
    input  logic              IF_ID_flush,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] IF_ID_instruction,
    output logic [PC_W-1:0]   IF_ID_pc_plus1,
    output logic              IF_ID_valid,
    output logic [1:0]        fetch_state
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_stalls,
    output logic [31:0]       stat_flushes
`endif
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic              in_fill, hold_pc, hold_ifid, flush, squash, load;

    assign pc_inc    = pc_q + PC_W'(1);
    assign imem_addr = pc_q;
    assign fetch_state = state_q;

    // The first cycle after reset always fetches; only a redirect can override it.
    assign in_fill   = (state_q == S_FILL);
    assign hold_pc   = pc_writebar   && !in_fill;
    assign hold_ifid = IF_ID_loadbar && !in_fill;
    assign flush     = IF_ID_flush   && !in_fill;
    assign squash    = redirect || flush;
    assign load      = !squash && !hold_ifid;

    always_comb begin
        pc_d    = pc_inc;
        state_d = state_q;
        if (redirect)
            pc_d = redirect_pc;
        else if (hold_pc)
            pc_d = pc_q;

        case (state_q)
            S_FILL:  state_d = S_RUN;
            S_RUN: begin
                if (!squash && (pc_writebar || IF_ID_loadbar))
                    state_d = S_STALL;
            end
            S_STALL: begin
                if (redirect || (!pc_writebar && !IF_ID_loadbar))
                    state_d = S_RUN;
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FILL;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A squashed slot keeps its pc_plus1 so only the instruction and valid change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IF_ID_instruction <= NOP_WORD;
            IF_ID_pc_plus1    <= '0;
            IF_ID_valid       <= 1'b0;
        end else if (squash) begin
            IF_ID_instruction <= NOP_WORD;
            IF_ID_valid       <= 1'b0;
        end else if (load) begin
            IF_ID_instruction <= imem_data;
            IF_ID_pc_plus1    <= pc_inc;
            IF_ID_valid       <= 1'b1;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetched <= '0;
            stat_stalls  <= '0;
            stat_flushes <= '0;
        end else begin
            if (load && stat_fetched != 32'hFFFF_FFFF)
                stat_fetched <= stat_fetched + 32'd1;
            if (state_q == S_STALL && stat_stalls != 32'hFFFF_FFFF)
                stat_stalls <= stat_stalls + 32'd1;
            if (squash && stat_flushes != 32'hFFFF_FFFF)
                stat_flushes <= stat_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural fetch model
module tb_fetch_stage;
    localparam int PC_W   = 12;
    localparam int INST_W = 19;
    localparam int DEPTH  = 1 << PC_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              pwb = 1'b0, lb = 1'b0, fl = 1'b0, rd = 1'b0;
    logic [PC_W-1:0]   rpc = '0;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] ins;
    logic [PC_W-1:0]   pp1;
    logic              valid;
    logic [1:0]        fstate;
`ifdef FETCH_STATS_EN
    logic [31:0]       st_fetched, st_stalls, st_flushes;
    int unsigned       m_fetched, m_stalls, m_flushes;
`endif

    logic [INST_W-1:0] imem [DEPTH];
    assign imem_data = imem[imem_addr];

    fetch_stage #(.PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk(clk), .reset(reset), .pc_writebar(pwb), .IF_ID_loadbar(lb),
        .IF_ID_flush(fl), .redirect(rd), .redirect_pc(rpc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .IF_ID_instruction(ins), .IF_ID_pc_plus1(pp1), .IF_ID_valid(valid),
        .fetch_state(fstate)
`ifdef FETCH_STATS_EN
        , .stat_fetched(st_fetched), .stat_stalls(st_stalls), .stat_flushes(st_flushes)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: 0 = FILL, 1 = RUN, 2 = STALL
    int                m_state;
    logic [PC_W-1:0]   m_pc, m_pp1;
    logic [INST_W-1:0] m_ins;
    logic              m_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = '0; m_pp1 = '0; m_ins = '0; m_valid = 1'b0;
`ifdef FETCH_STATS_EN
        m_fetched = 0; m_stalls = 0; m_flushes = 0;
`endif
    endtask

    task automatic model_step(input logic p, input logic l, input logic f,
                              input logic r, input logic [PC_W-1:0] t);
        bit fill, ep, el, ef, squash;
        int next_state;
        fill = (m_state == 0);
        ep = p && !fill; el = l && !fill; ef = f && !fill;
        squash = r || ef;
`ifdef FETCH_STATS_EN
        if (m_state == 2) m_stalls++;
        if (squash) m_flushes++;
        else if (!el) m_fetched++;
`endif
        if (fill)            next_state = 1;
        else if (r)          next_state = 1;
        else if (m_state == 1) next_state = (!ef && (p || l)) ? 2 : 1;
        else                 next_state = (!p && !l) ? 1 : 2;

        if (squash) begin
            m_ins = '0; m_valid = 1'b0;
        end else if (!el) begin
            m_ins = imem[m_pc];
            m_pp1 = PC_W'((int'(m_pc) + 1) % DEPTH);
            m_valid = 1'b1;
        end
        if (r)        m_pc = t;
        else if (!ep) m_pc = PC_W'((int'(m_pc) + 1) % DEPTH);
        m_state = next_state;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    32'(imem_addr), 32'(m_pc));
        chk({tag, ".ins"},   32'(ins),       32'(m_ins));
        chk({tag, ".pp1"},   32'(pp1),       32'(m_pp1));
        chk({tag, ".valid"}, 32'(valid),     32'(m_valid));
        chk({tag, ".state"}, 32'(fstate),    32'(m_state));
`ifdef FETCH_STATS_EN
        chk({tag, ".fetched"}, st_fetched, m_fetched);
        chk({tag, ".stalls"},  st_stalls,  m_stalls);
        chk({tag, ".flushes"}, st_flushes, m_flushes);
`endif
    endtask

    task automatic cycle(input string tag, input logic p, input logic l, input logic f,
                         input logic r, input logic [PC_W-1:0] t);
        pwb = p; lb = l; fl = f; rd = r; rpc = t;
        @(posedge clk); #1;
        model_step(p, l, f, r, t);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #3 reset = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(posedge clk); #1;
        check_all({tag, ".held"});
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) imem[i] = INST_W'($urandom);
        model_reset();

        // T1: reset held three edges, then fetch imem[0], imem[1]
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        reset = 1'b1;
        cycle("t1e1", 0, 0, 0, 0, '0);
        chk("t1e1.ins_imem0", 32'(ins), 32'(imem[0]));
        chk("t1e1.pp1_one",   32'(pp1), 32'd1);
        cycle("t1e2", 0, 0, 0, 0, '0);
        chk("t1e2.ins_imem1", 32'(ins), 32'(imem[1]));
        repeat (3) cycle("run", 0, 0, 0, 0, '0);

        // T2: two stalled cycles at PC=5
        cycle("t2s1", 1, 1, 0, 0, '0);
        cycle("t2s2", 1, 1, 0, 0, '0);
        chk("t2.pc_held",  32'(imem_addr), 32'd5);
        chk("t2.ins_held", 32'(ins),       32'(imem[4]));
        cycle("t2rel", 0, 0, 0, 0, '0);
        chk("t2rel.ins", 32'(ins),       32'(imem[5]));
        chk("t2rel.pc",  32'(imem_addr), 32'd6);
        chk("t2rel.run", 32'(fstate),    32'd1);
        repeat (3) cycle("run", 0, 0, 0, 0, '0);

        // T3: redirect at PC=9 to 0x040
        chk("t3.pc9", 32'(imem_addr), 32'd9);
        cycle("t3r", 0, 0, 0, 1, 12'h040);
        chk("t3r.valid", 32'(valid), 32'd0);
        cycle("t3f", 0, 0, 0, 0, '0);
        chk("t3f.ins", 32'(ins), 32'(imem[12'h040]));
        chk("t3f.pp1", 32'(pp1), 32'h041);

        // T4: conflicting controls
        cycle("t4a", 1, 0, 0, 1, 12'h123);
        chk("t4a.pc", 32'(imem_addr), 32'h123);
        cycle("t4b", 0, 1, 1, 0, '0);
        chk("t4b.valid", 32'(valid), 32'd0);
        cycle("t4c", 1, 0, 0, 0, '0);
        cycle("t4d", 0, 0, 0, 0, '0);

        // T5: PC wrap at 2^PC_W-1
        cycle("t5r", 0, 0, 0, 1, 12'hFFF);
        cycle("t5w", 0, 0, 0, 0, '0);
        chk("t5.pc_wrap",  32'(imem_addr), 32'd0);
        chk("t5.pp1_wrap", 32'(pp1),       32'd0);

        // T6: asynchronous reset between edges while stalled
        cycle("t6s1", 1, 1, 0, 0, '0);
        cycle("t6s2", 1, 1, 0, 0, '0);
        cycle("t6s3", 1, 0, 0, 0, '0);
        async_reset("t6");
        cycle("t6fill", 1, 1, 1, 0, '0);

        // Randomized traffic with occasional mid-cycle resets
        for (int n = 0; n < 600; n++) begin
            cycle("rnd", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                  PC_W'($urandom));
            if ($urandom_range(0, 63) == 0) async_reset("rnd_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
